// File: rtl/muldiv_seq_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, followed by a single sign-fix/commit cycle.
module muldiv_seq_unit #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [FUNCT_W-1:0] F_MTHI  = FUNCT_W'(6'h11);
  localparam logic [FUNCT_W-1:0] F_MTLO  = FUNCT_W'(6'h13);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'h18);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'h19);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'h1A);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'h1B);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               op_div_r;
  logic               b_zero_r;
  logic               neg_prod_r;
  logic               neg_quo_r;
  logic               neg_rem_r;
  logic [WIDTH-1:0]   src_a_r;
  logic [WIDTH-1:0]   d_r;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_r;   // product high half or partial remainder
  logic [WIDTH-1:0]   work_r;  // multiplier bits shifting out / quotient bits shifting in

  logic               sgn_op_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic               div_ge_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  // Operand sign decode, magnitudes and one iteration of the datapath
  always_comb begin
    sgn_op_s = (funct == F_MULT) || (funct == F_DIV);
    a_neg_s  = sgn_op_s & a[WIDTH-1];
    b_neg_s  = sgn_op_s & b[WIDTH-1];
    if (a_neg_s) begin
      mag_a_s = WIDTH'(0) - a;
    end else begin
      mag_a_s = a;
    end
    if (b_neg_s) begin
      mag_b_s = WIDTH'(0) - b;
    end else begin
      mag_b_s = b;
    end
    if (work_r[0]) begin
      mul_sum_s = {1'b0, acc_r} + {1'b0, d_r};
    end else begin
      mul_sum_s = {1'b0, acc_r};
    end
    div_shift_s = {acc_r, work_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, d_r});
    div_diff_s  = div_shift_s - {1'b0, d_r};
    if (neg_prod_r) begin
      prod_fix_s = (2*WIDTH)'(0) - {acc_r, work_r};
    end else begin
      prod_fix_s = {acc_r, work_r};
    end
    if (neg_quo_r) begin
      quo_fix_s = WIDTH'(0) - work_r;
    end else begin
      quo_fix_s = work_r;
    end
    if (neg_rem_r) begin
      rem_fix_s = WIDTH'(0) - acc_r;
    end else begin
      rem_fix_s = acc_r;
    end
  end

  // Control FSM, iteration registers and HI/LO commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      op_div_r   <= 1'b0;
      b_zero_r   <= 1'b0;
      neg_prod_r <= 1'b0;
      neg_quo_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      src_a_r    <= '0;
      d_r        <= '0;
      acc_r      <= '0;
      work_r     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            case (funct)
              F_MULT, F_MULTU: begin
                state_r    <= MUL;
                busy       <= 1'b1;
                cnt_r      <= '0;
                op_div_r   <= 1'b0;
                neg_prod_r <= a_neg_s ^ b_neg_s;
                acc_r      <= '0;
                work_r     <= mag_a_s;
                d_r        <= mag_b_s;
              end
              F_DIV, F_DIVU: begin
                state_r   <= DIV;
                busy      <= 1'b1;
                cnt_r     <= '0;
                op_div_r  <= 1'b1;
                neg_quo_r <= a_neg_s ^ b_neg_s;
                neg_rem_r <= a_neg_s;
                b_zero_r  <= (b == '0);
                src_a_r   <= a;
                acc_r     <= '0;
                work_r    <= mag_a_s;
                d_r       <= mag_b_s;
              end
              F_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              F_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end
        end
        MUL: begin
          acc_r  <= mul_sum_s[WIDTH:1];
          work_r <= {mul_sum_s[0], work_r[WIDTH-1:1]};
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_ITER) begin
            state_r <= FIX;
          end
        end
        DIV: begin
          // A zero divisor always "fits", yielding all-ones quotient; FIX overrides it anyway
          if (div_ge_s) begin
            acc_r <= div_diff_s[WIDTH-1:0];
          end else begin
            acc_r <= div_shift_s[WIDTH-1:0];
          end
          work_r <= {work_r[WIDTH-2:0], div_ge_s};
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_ITER) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (!op_div_r) begin
            {hi, lo} <= prod_fix_s;
          end else if (b_zero_r) begin
            lo <= '1;
            hi <= src_a_r;
          end else begin
            lo <= quo_fix_s;
            hi <= rem_fix_s;
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          cnt_r   <= '0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: 32-bit instance plus an 8-bit instance.
module tb_muldiv_seq_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, busy, done;
  logic [5:0]  funct;
  logic [31:0] a, b, hi, lo;
  logic        start8, busy8, done8;
  logic [5:0]  funct8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_checks = 0;
  int n_errors = 0;
  bit overlap  = 1'b0;
  int lat, bcnt;

  muldiv_seq_unit #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_seq_unit #(.WIDTH(8), .FUNCT_W(6)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .funct(funct8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  always @(negedge clk) begin
    if ((busy && done) || (busy8 && done8)) overlap <= 1'b1;
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                        output int l, output int bc);
    @(negedge clk);
    start = 1'b1; funct = f; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5; funct = 6'h19;
    bc = busy ? 1 : 0;
    l  = 0;
    while (!done && l < 200) begin
      @(posedge clk); #1;
      l++;
      if (busy) bc++;
    end
  endtask

  task automatic check_op(input string tag, input logic [5:0] f, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    int l, bc;
    run_op(f, av, bv, l, bc);
    check_value({tag, "_lat"}, 64'(l), 64'd33);
    check_value({tag, "_hi"}, 64'(hi), 64'(eh));
    check_value({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  task automatic check_op8(input string tag, input logic [5:0] f, input logic [7:0] av,
                           input logic [7:0] bv, input logic [7:0] eh, input logic [7:0] el);
    int l;
    @(negedge clk);
    start8 = 1'b1; funct8 = f; a8 = av; b8 = bv;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    l = 0;
    while (!done8 && l < 200) begin
      @(posedge clk); #1;
      l++;
    end
    check_value({tag, "_lat"}, 64'(l), 64'd9);
    check_value({tag, "_hi"}, 64'(hi8), 64'(eh));
    check_value({tag, "_lo"}, 64'(lo8), 64'(el));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct = 6'h00; a = 32'h0; b = 32'h0;
    start8 = 1'b0; funct8 = 6'h00; a8 = 8'h0; b8 = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_hi", 64'(hi), 64'd0);
    check_value("rst_lo", 64'(lo), 64'd0);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_done", 64'(done), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    check_value("multu_max_lat", 64'(lat), 64'd33);
    check_value("multu_max_busy", 64'(bcnt), 64'd33);
    check_value("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check_value("multu_max_lo", 64'(lo), 64'h0000_0001);

    check_op("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    check_op("mult_minsq", 6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    check_op("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    check_op("divu", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
    check_op("divu_zero", 6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    check_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // MTHI takes effect at the accept edge, done in the next cycle, never busy
    @(negedge clk); start = 1'b1; funct = 6'h11; a = 32'h1234;
    @(posedge clk); #1; start = 1'b0;
    check_value("mthi_hi", 64'(hi), 64'h1234);
    check_value("mthi_done", 64'(done), 64'd1);
    check_value("mthi_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_value("mthi_done_drop", 64'(done), 64'd0);

    // MTLO during a MULTU must be dropped
    @(negedge clk); start = 1'b1; funct = 6'h19; a = 32'd3; b = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); start = 1'b1; funct = 6'h13; a = 32'hDEAD;
    @(posedge clk); #1; start = 1'b0;
    check_value("mtlo_busy_lo", 64'(lo), 64'h8000_0000);
    check_value("mtlo_busy_done", 64'(done), 64'd0);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_value("mul_after_mtlo_lo", 64'(lo), 64'd12);
    check_value("mul_after_mtlo_hi", 64'(hi), 64'd0);

    // Second op issued in the done cycle of the first
    run_op(6'h19, 32'd6, 32'd7, lat, bcnt);
    check_value("b2b_first_lo", 64'(lo), 64'd42);
    check_op("b2b_second", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);

    // Reset ten cycles into a MULT aborts it
    @(negedge clk); start = 1'b1; funct = 6'h18; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_value("abort_busy", 64'(busy), 64'd0);
    check_value("abort_done", 64'(done), 64'd0);
    check_value("abort_hi", 64'(hi), 64'd0);
    check_value("abort_lo", 64'(lo), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("abort_no_done", 64'(done), 64'd0);
    check_op("post_abort_divu", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);

    check_op8("w8_multu", 6'h19, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    check_op8("w8_div_neg", 6'h1A, 8'hF9, 8'h02, 8'hFF, 8'hFD);

    check_value("busy_done_overlap", 64'(overlap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
